// File: rtl/hex_step_counter.sv
// hex_step_counter: button-driven hex digit source for a seven-segment decoder.
// Three raw active-low buttons (up, down, load) are synchronised and debounced.
// The registered digit steps with wrap-around. A held up/down button
// auto-repeats, and load copies the synchronised slide switches into the digit.
//
// Repeat FSM
//   state     | meaning
//   ST_IDLE   | no auto-repeat pending; waits for an accepted up/down step
//   ST_DELAY  | button held after the first step; timer counts the initial delay
//   ST_REPEAT | auto-repeating; one step every time the timer reaches zero

module hex_step_counter #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up_n,
    input  logic       btn_dn_n,
    input  logic       btn_ld_n,
    input  logic [3:0] sw,
    output logic [3:0] digit,
    output logic       step,
    output logic       carry,
    output logic       borrow
);

    // The debounce counter only has to hold DEBOUNCE_CYCLES-1.
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // One shared down-counter covers both the initial delay and the period.
    localparam int TM_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TM_W   = $clog2(TM_MAX + 1);
    localparam logic [TM_W-1:0] TM_DELAY  = TM_W'(REPEAT_DELAY - 1);
    localparam logic [TM_W-1:0] TM_PERIOD = TM_W'(REPEAT_PERIOD - 1);

    // Button slot order inside the packed button vectors.
    localparam int BTN_UP = 0;
    localparam int BTN_DN = 1;
    localparam int BTN_LD = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    logic [2:0]      w_btn_raw;
    logic [2:0]      r_btn_s1;
    logic [2:0]      r_btn_s2;
    logic [3:0]      r_sw_s1;
    logic [3:0]      r_sw_s2;

    logic [2:0]      w_db_lvl;    // debounced level, 1 = released
    logic [2:0]      w_press;     // one-cycle released->pressed event

    logic            w_ld_ev;
    logic            w_up_ev;
    logic            w_dn_ev;
    logic            w_up_held;
    logic            w_dn_held;
    logic            w_start;
    logic            w_abort;
    logic            w_rpt_step;

    rpt_state_t      r_state;
    logic            r_dir_up;
    logic [TM_W-1:0] r_timer;

    logic [3:0]      w_digit_nxt;
    logic            w_inc;
    logic            w_dec;
    logic [3:0]      r_digit;
    logic            r_step;
    logic            r_carry;
    logic            r_borrow;

    assign w_btn_raw = {btn_ld_n, btn_dn_n, btn_up_n};

    // Two-flop synchronisers; reset to the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1 <= 3'b111;
            r_btn_s2 <= 3'b111;
            r_sw_s1  <= 4'hF;
            r_sw_s2  <= 4'hF;
        end else begin
            r_btn_s1 <= w_btn_raw;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_db
            logic            r_lvl;
            logic [DB_W-1:0] r_cnt;
            logic            r_prs;

            // Count consecutive mismatch cycles; flip the level once the
            // mismatch has lasted DEBOUNCE_CYCLES cycles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_lvl <= 1'b1;
                    r_cnt <= '0;
                    r_prs <= 1'b0;
                end else begin
                    r_prs <= 1'b0;
                    if (r_btn_s2[g] == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_lvl <= r_btn_s2[g];
                        r_cnt <= '0;
                        r_prs <= ~r_btn_s2[g];
                    end else begin
                        r_cnt <= r_cnt + DB_W'(1);
                    end
                end
            end

            assign w_db_lvl[g] = r_lvl;
            assign w_press[g]  = r_prs;
        end
    endgenerate

    assign w_up_held = ~w_db_lvl[BTN_UP];
    assign w_dn_held = ~w_db_lvl[BTN_DN];

    // A press event only counts when the other direction is not held; a press
    // on the other button in the same cycle already shows up as held.
    assign w_ld_ev = w_press[BTN_LD];
    assign w_up_ev = w_press[BTN_UP] & ~w_dn_held;
    assign w_dn_ev = w_press[BTN_DN] & ~w_up_held;

    // Load outranks up/down, so a simultaneous press never starts a repeat.
    assign w_start = ~w_ld_ev & (w_up_ev | w_dn_ev);

    assign w_abort = (r_state != ST_IDLE) &&
                     (w_ld_ev ||
                      (r_dir_up ? (!w_up_held || w_dn_held)
                                : (!w_dn_held || w_up_held)));

    assign w_rpt_step = (r_state != ST_IDLE) && !w_abort && !w_start &&
                        (r_timer == '0);

    // Repeat FSM with its shared down-counter timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_dir_up <= 1'b0;
            r_timer  <= '0;
        end else if (w_start) begin
            r_state  <= ST_DELAY;
            r_dir_up <= w_up_ev;
            r_timer  <= TM_DELAY;
        end else if (w_abort) begin
            r_state  <= ST_IDLE;
        end else if (r_state != ST_IDLE) begin
            if (r_timer == '0) begin
                r_state <= ST_REPEAT;
                r_timer <= TM_PERIOD;
            end else begin
                r_timer <= r_timer - TM_W'(1);
            end
        end
    end

    // Next digit value in priority order: load, up, down.
    always_comb begin
        w_digit_nxt = r_digit;
        w_inc       = 1'b0;
        w_dec       = 1'b0;
        if (w_ld_ev) begin
            w_digit_nxt = r_sw_s2;
        end else if (w_up_ev || (w_rpt_step && r_dir_up)) begin
            w_inc       = 1'b1;
            w_digit_nxt = r_digit + 4'd1;
        end else if (w_dn_ev || (w_rpt_step && !r_dir_up)) begin
            w_dec       = 1'b1;
            w_digit_nxt = r_digit - 4'd1;
        end
    end

    // Registered digit and pulses; step follows any actual change of value,
    // so a load of the same value stays silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit  <= 4'h0;
            r_step   <= 1'b0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            r_digit  <= w_digit_nxt;
            r_step   <= (w_digit_nxt != r_digit);
            r_carry  <= w_inc & (r_digit == 4'hF);
            r_borrow <= w_dec & (r_digit == 4'h0);
        end
    end

    assign digit  = r_digit;
    assign step   = r_step;
    assign carry  = r_carry;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_hex_step_counter.sv
// Bench for hex_step_counter: directed scenarios followed by random button
// traffic, all outputs compared every cycle against a behavioural model.

module tb_hex_step_counter;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up_n;
    logic       btn_dn_n;
    logic       btn_ld_n;
    logic [3:0] sw;
    logic [3:0] digit;
    logic       step;
    logic       carry;
    logic       borrow;

    int n_cmp = 0;
    int n_bad = 0;

    hex_step_counter #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up_n (btn_up_n),
        .btn_dn_n (btn_dn_n),
        .btn_ld_n (btn_ld_n),
        .sw       (sw),
        .digit    (digit),
        .step     (step),
        .carry    (carry),
        .borrow   (borrow)
    );

    always #5 clk = ~clk;

    // Behavioural model: raw inputs delayed two cycles, a level is accepted
    // after DB consecutive differing cycles, repeat steps scheduled by
    // absolute cycle number.
    int         m_edge;
    logic [6:0] m_p1;
    logic [6:0] m_p2;
    logic       m_lvl [3];
    int         m_run [3];
    logic       m_press [3];
    logic [3:0] m_digit;
    logic       m_step;
    logic       m_carry;
    logic       m_borrow;
    logic       m_rpt_on;
    logic       m_rpt_up;
    int         m_rpt_due;

    task automatic chk_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_p1     = 7'h7F;
        m_p2     = 7'h7F;
        for (int i = 0; i < 3; i++) begin
            m_lvl[i]   = 1'b1;
            m_run[i]   = 0;
            m_press[i] = 1'b0;
        end
        m_digit  = 4'h0;
        m_step   = 1'b0;
        m_carry  = 1'b0;
        m_borrow = 1'b0;
        m_rpt_on = 1'b0;
        m_rpt_up = 1'b0;
    endtask

    task automatic model_tick();
        logic ld_ev, up_ev, dn_ev, up_held, dn_held, s;
        int   delta, v;
        logic [3:0] old_d, nd;
        m_edge++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ld_ev   = m_press[2];
        up_ev   = m_press[0] && m_lvl[1];
        dn_ev   = m_press[1] && m_lvl[0];
        up_held = !m_lvl[0];
        dn_held = !m_lvl[1];
        old_d   = m_digit;
        nd      = old_d;
        delta   = 0;
        if (m_rpt_on && (ld_ev || (m_rpt_up ? (!up_held || dn_held) : (!dn_held || up_held))))
            m_rpt_on = 1'b0;
        if (ld_ev) begin
            nd = m_p2[6:3];
        end else if (up_ev) begin
            delta = 1;  m_rpt_on = 1'b1; m_rpt_up = 1'b1; m_rpt_due = m_edge + RD;
        end else if (dn_ev) begin
            delta = -1; m_rpt_on = 1'b1; m_rpt_up = 1'b0; m_rpt_due = m_edge + RD;
        end else if (m_rpt_on && m_edge == m_rpt_due) begin
            delta = m_rpt_up ? 1 : -1;
            m_rpt_due = m_edge + RP;
        end
        m_carry  = 1'b0;
        m_borrow = 1'b0;
        if (delta != 0) begin
            v        = int'(old_d) + delta;
            m_carry  = (v == 16);
            m_borrow = (v == -1);
            nd       = 4'((v + 16) % 16);
        end
        m_step  = (nd != old_d);
        m_digit = nd;
        for (int i = 0; i < 3; i++) begin
            s          = m_p2[i];
            m_press[i] = 1'b0;
            if (s != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_lvl[i]   = s;
                    m_run[i]   = 0;
                    m_press[i] = !s;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_p2 = m_p1;
        m_p1 = {sw, btn_ld_n, btn_dn_n, btn_up_n};
    endtask

    task automatic compare_all();
        chk_eq("digit",  digit,             m_digit);
        chk_eq("step",   {3'b000, step},    {3'b000, m_step});
        chk_eq("carry",  {3'b000, carry},   {3'b000, m_carry});
        chk_eq("borrow", {3'b000, borrow},  {3'b000, m_borrow});
    endtask

    task automatic tick();
        model_tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_in(input logic u, input logic d, input logic l, input logic [3:0] s);
        btn_up_n = u;
        btn_dn_n = d;
        btn_ld_n = l;
        sw       = s;
    endtask

    task automatic hold(input logic u, input logic d, input logic l, input logic [3:0] s, input int n);
        set_in(u, d, l, s);
        repeat (n) tick();
    endtask

    task automatic load_val(input logic [3:0] s);
        hold(1'b1, 1'b1, 1'b0, s, 9);
        hold(1'b1, 1'b1, 1'b1, s, 15);
    endtask

    int up_left, dn_left, ld_left;

    initial begin
        m_edge = 0;
        rst_n  = 1'b0;
        set_in(1'b1, 1'b1, 1'b1, 4'h0);
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk_eq("rst_digit", digit, 4'h0);
        chk_eq("rst_step",  {3'b000, step}, 4'h0);

        // Single press: digit changes 7 edges after the press, step one cycle.
        set_in(1'b0, 1'b1, 1'b1, 4'h0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 6) chk_eq("press_pre", digit, 4'h0);
            if (i == 7) begin
                chk_eq("press_digit", digit, 4'h1);
                chk_eq("press_step",  {3'b000, step}, 4'h1);
            end
            if (i == 8) chk_eq("press_step_off", {3'b000, step}, 4'h0);
        end
        hold(1'b1, 1'b1, 1'b1, 4'h0, 30);
        chk_eq("release_no_step", digit, 4'h1);

        // Glitch, then bounce, then a settled press.
        hold(1'b0, 1'b1, 1'b1, 4'h0, 3);
        hold(1'b1, 1'b1, 1'b1, 4'h0, 5);
        for (int k = 0; k < 3; k++) begin
            hold(1'b0, 1'b1, 1'b1, 4'h0, 2);
            hold(1'b1, 1'b1, 1'b1, 4'h0, 2);
        end
        chk_eq("glitch_none", digit, 4'h1);
        set_in(1'b0, 1'b1, 1'b1, 4'h0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 6) chk_eq("settle_pre", digit, 4'h1);
            if (i == 7) chk_eq("settle_inc", digit, 4'h2);
        end
        hold(1'b1, 1'b1, 1'b1, 4'h0, 20);

        // Wrap: load F, up to 0 with carry, down to F with borrow.
        set_in(1'b1, 1'b1, 1'b0, 4'hF);
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 7) chk_eq("load_f", digit, 4'hF);
        end
        hold(1'b1, 1'b1, 1'b1, 4'hF, 15);
        set_in(1'b0, 1'b1, 1'b1, 4'hF);
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 7) begin
                chk_eq("wrap_up",   digit, 4'h0);
                chk_eq("carry_on",  {3'b000, carry}, 4'h1);
            end
            if (i == 8) chk_eq("carry_off", {3'b000, carry}, 4'h0);
        end
        hold(1'b1, 1'b1, 1'b1, 4'hF, 15);
        set_in(1'b1, 1'b0, 1'b1, 4'hF);
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 7) begin
                chk_eq("wrap_dn",   digit, 4'hF);
                chk_eq("borrow_on", {3'b000, borrow}, 4'h1);
            end
        end
        hold(1'b1, 1'b1, 1'b1, 4'hF, 15);

        // Down auto-repeat from 5, cancelled by the up button.
        load_val(4'h5);
        for (int i = 1; i <= 45; i++) begin
            set_in((i >= 19 && i < 35) ? 1'b0 : 1'b1, 1'b0, 1'b1, 4'h5);
            tick();
            if (i == 7)  chk_eq("rpt_first", digit, 4'h4);
            if (i == 16) chk_eq("rpt_wait",  digit, 4'h4);
            if (i == 17) chk_eq("rpt_delay", digit, 4'h3);
            if (i == 20) chk_eq("rpt_per1",  digit, 4'h2);
            if (i == 23) chk_eq("rpt_per2",  digit, 4'h1);
            if (i == 45) chk_eq("rpt_stop",  digit, 4'h1);
        end
        hold(1'b1, 1'b1, 1'b1, 4'h5, 15);

        // Load and up together: load wins; same-value load gives no step.
        load_val(4'h3);
        set_in(1'b0, 1'b1, 1'b0, 4'hA);
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 7) begin
                chk_eq("ld_wins",  digit, 4'hA);
                chk_eq("ld_carry", {3'b000, carry}, 4'h0);
            end
        end
        hold(1'b1, 1'b1, 1'b1, 4'hA, 15);
        set_in(1'b1, 1'b1, 1'b0, 4'hA);
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 7) chk_eq("ld_same_step", {3'b000, step}, 4'h0);
        end
        hold(1'b1, 1'b1, 1'b1, 4'hA, 15);

        // Reset in the middle of an up repeat at digit 9.
        load_val(4'h6);
        set_in(1'b0, 1'b1, 1'b1, 4'h6);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 20) chk_eq("pre_rst_digit", digit, 4'h9);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_eq("async_rst_digit", digit, 4'h0);
        chk_eq("async_rst_pulse", {1'b0, step, carry, borrow}, 4'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 6) chk_eq("post_rst_pre", digit, 4'h0);
        end
        hold(1'b1, 1'b1, 1'b1, 4'h6, 20);

        // Random button traffic.
        up_left = 0;
        dn_left = 0;
        ld_left = 20;
        for (int c = 0; c < 4000; c++) begin
            if (up_left == 0) begin
                btn_up_n = ~btn_up_n;
                up_left  = $urandom_range(1, 24);
            end else up_left--;
            if (dn_left == 0) begin
                btn_dn_n = ~btn_dn_n;
                dn_left  = $urandom_range(1, 30);
            end else dn_left--;
            if (ld_left == 0) begin
                btn_ld_n = ~btn_ld_n;
                ld_left  = btn_ld_n ? $urandom_range(1, 12) : $urandom_range(10, 60);
            end else ld_left--;
            if ($urandom_range(0, 15) == 0) sw = 4'($urandom_range(0, 15));
            if (c == 2000) rst_n = 1'b0;
            if (c == 2003) rst_n = 1'b1;
            tick();
        end
        hold(1'b1, 1'b1, 1'b1, 4'h0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
